// File: rtl/load_power_scheduler.sv
// Purpose: share a live power budget among cooler, heater and light loads by fixed priority,
//          with minimum on-time, restart lockout, over-budget shedding and conflict/starve alarms.
// Latency: one cycle from request/budget to *_en; no backpressure, acts on every cycle.
module load_power_scheduler #(
  parameter logic [8:0] HEATER_LOAD  = 9'd200,
  parameter logic [8:0] COOLER_LOAD  = 9'd150,
  parameter logic [8:0] LIGHT_LOAD   = 9'd40,
  parameter int         MIN_ON       = 8,
  parameter int         MIN_OFF      = 4,
  parameter int         STARVE_LIMIT = 16,
  parameter int         CW           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_heater,
  input  logic       req_cooler,
  input  logic       req_light,
  input  logic [8:0] power_budget,
  output logic       heater_en,
  output logic       cooler_en,
  output logic       light_en,
  output logic [9:0] load_total,
  output logic       conflict_alarm,
  output logic       starve_alarm
);

  // Channel index doubles as priority: 0 = cooler (highest), 1 = heater, 2 = light (lowest).
  localparam int NCH = 3;
  localparam logic [CW-1:0] MIN_ON_C  = CW'(MIN_ON);
  localparam logic [CW-1:0] MIN_OFF_C = CW'(MIN_OFF);
  localparam logic [CW-1:0] STARVE_C  = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_ON   = 2'd1,
    ST_LOCK = 2'd2
  } ch_state_t;

  ch_state_t     state   [NCH];
  ch_state_t     state_n [NCH];
  logic [CW-1:0] on_cnt     [NCH];
  logic [CW-1:0] on_cnt_n   [NCH];
  logic [CW-1:0] off_cnt    [NCH];
  logic [CW-1:0] off_cnt_n  [NCH];
  logic [CW-1:0] starve_cnt [NCH];
  logic [CW-1:0] starve_n   [NCH];

  logic [NCH-1:0] req;
  logic [9:0]     budget;
  logic [9:0]     used;
  logic [9:0]     total_n;
  logic           shed_act;
  logic [1:0]     shed_idx;
  logic [NCH-1:0] rel_elig;
  logic           rel_act;
  logic           grant_act;
  logic [1:0]     grant_idx;
  logic           starve_hit;

  function automatic logic [9:0] load_of(input int idx);
    case (idx)
      0:       load_of = {1'b0, COOLER_LOAD};
      1:       load_of = {1'b0, HEATER_LOAD};
      default: load_of = {1'b0, LIGHT_LOAD};
    endcase
  endfunction

  assign req    = {req_light, req_heater, req_cooler};
  assign budget = {1'b0, power_budget};

  // Arbitration: shed beats release beats grant; then per-channel next state and counters.
  always_comb begin
    used       = '0;
    total_n    = '0;
    shed_idx   = 2'd0;
    shed_act   = 1'b0;
    rel_elig   = '0;
    grant_act  = 1'b0;
    grant_idx  = 2'd0;
    starve_hit = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      state_n[i]   = state[i];
      on_cnt_n[i]  = '0;
      off_cnt_n[i] = '0;
      starve_n[i]  = '0;
    end

    for (int i = 0; i < NCH; i++) begin
      if (state[i] == ST_ON) begin
        used = used + load_of(i);
      end
    end

    // Later (lower-priority) ON channels overwrite, so the lowest-priority one is shed.
    for (int i = 0; i < NCH; i++) begin
      if (state[i] == ST_ON) begin
        shed_idx = 2'(i);
      end
    end
    shed_act = (used > budget);

    for (int i = 0; i < NCH; i++) begin
      rel_elig[i] = (state[i] == ST_ON) && !req[i] && (on_cnt[i] == MIN_ON_C);
    end
    rel_act = !shed_act && (rel_elig != '0);

    // Walk lowest to highest priority so the highest-priority eligible channel wins.
    for (int i = NCH - 1; i >= 0; i--) begin
      if ((state[i] == ST_OFF) && req[i] && ((used + load_of(i)) <= budget) &&
          ((i != 1) || (!req_cooler && (state[0] != ST_ON)))) begin
        grant_act = 1'b1;
        grant_idx = 2'(i);
      end
    end
    grant_act = grant_act && !shed_act && !rel_act;

    for (int i = 0; i < NCH; i++) begin
      case (state[i])
        ST_ON: begin
          if ((shed_act && (shed_idx == 2'(i))) || (rel_act && rel_elig[i])) begin
            state_n[i]   = ST_LOCK;
            off_cnt_n[i] = CW'(1);
          end else begin
            on_cnt_n[i] = (on_cnt[i] == MIN_ON_C) ? on_cnt[i] : on_cnt[i] + CW'(1);
          end
        end
        ST_LOCK: begin
          if (off_cnt[i] == MIN_OFF_C) begin
            state_n[i] = ST_OFF;
          end else begin
            off_cnt_n[i] = off_cnt[i] + CW'(1);
          end
        end
        default: begin
          if (grant_act && (grant_idx == 2'(i))) begin
            state_n[i]  = ST_ON;
            on_cnt_n[i] = CW'(1);
          end
        end
      endcase

      if (req[i] && (state[i] != ST_ON)) begin
        starve_n[i] = (starve_cnt[i] == STARVE_C) ? starve_cnt[i] : starve_cnt[i] + CW'(1);
      end
      if (starve_n[i] == STARVE_C) begin
        starve_hit = 1'b1;
      end
      if (state_n[i] == ST_ON) begin
        total_n = total_n + load_of(i);
      end
    end
  end

  // State, counters and registered outputs; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        state[i]      <= ST_OFF;
        on_cnt[i]     <= '0;
        off_cnt[i]    <= '0;
        starve_cnt[i] <= '0;
      end
      cooler_en      <= 1'b0;
      heater_en      <= 1'b0;
      light_en       <= 1'b0;
      load_total     <= '0;
      conflict_alarm <= 1'b0;
      starve_alarm   <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state[i]      <= state_n[i];
        on_cnt[i]     <= on_cnt_n[i];
        off_cnt[i]    <= off_cnt_n[i];
        starve_cnt[i] <= starve_n[i];
      end
      cooler_en      <= (state_n[0] == ST_ON);
      heater_en      <= (state_n[1] == ST_ON);
      light_en       <= (state_n[2] == ST_ON);
      load_total     <= total_n;
      conflict_alarm <= req_heater & req_cooler;
      starve_alarm   <= starve_alarm | starve_hit;
    end
  end

endmodule

// File: tb/tb_load_power_scheduler.sv
// Purpose: directed stimulus with hand-computed per-edge expectations, checked by a scoreboard monitor.
// Latency: each expectation is compared 1 time unit after the edge it describes.
// Backpressure: none; one expectation is queued per checked step and popped by the monitor.
module tb_load_power_scheduler;

  logic       clk;
  logic       rst;
  logic       req_heater;
  logic       req_cooler;
  logic       req_light;
  logic [8:0] power_budget;
  logic       heater_en;
  logic       cooler_en;
  logic       light_en;
  logic [9:0] load_total;
  logic       conflict_alarm;
  logic       starve_alarm;

  int checks;
  int failures;

  // Expected vector layout: {heater_en, cooler_en, light_en, load_total[9:0], conflict, starve}
  logic [14:0] exp_q [$];
  string       name_q [$];

  load_power_scheduler dut (
    .clk            (clk),
    .rst            (rst),
    .req_heater     (req_heater),
    .req_cooler     (req_cooler),
    .req_light      (req_light),
    .power_budget   (power_budget),
    .heater_en      (heater_en),
    .cooler_en      (cooler_en),
    .light_en       (light_en),
    .load_total     (load_total),
    .conflict_alarm (conflict_alarm),
    .starve_alarm   (starve_alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] ex(input logic h, input logic c, input logic l,
                                     input int total, input logic conf, input logic stv);
    ex = {h, c, l, 10'(total), conf, stv};
  endfunction

  // Drive one cycle of inputs away from the edge and queue what the next edge must produce.
  task automatic step(input string nm, input logic r, input logic h, input logic c,
                      input logic l, input int b, input logic [14:0] e);
    @(negedge clk);
    rst          = r;
    req_heater   = h;
    req_cooler   = c;
    req_light    = l;
    power_budget = 9'(b);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
  endtask

  // Monitor: compare DUT outputs against the queued expectation after every edge.
  always @(posedge clk) begin
    logic [14:0] act;
    logic [14:0] e;
    string       nm;
    #1;
    if (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      act = {heater_en, cooler_en, light_en, load_total, conflict_alarm, starve_alarm};
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL %s: got h=%0b c=%0b l=%0b total=%0d conf=%0b starve=%0b, want h=%0b c=%0b l=%0b total=%0d conf=%0b starve=%0b",
                 nm, act[14], act[13], act[12], act[11:2], act[1], act[0],
                 e[14], e[13], e[12], e[11:2], e[1], e[0]);
      end
    end
  end

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    req_heater   = 1'b0;
    req_cooler   = 1'b0;
    req_light    = 1'b0;
    power_budget = '0;

    // Reset for two cycles, then a single light request.
    step("reset0", 1, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0));
    step("reset1", 1, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0));
    step("light_grant", 0, 0, 0, 1, 400, ex(0, 0, 1, 40, 0, 0));
    step("light_hold", 0, 0, 0, 1, 400, ex(0, 0, 1, 40, 0, 0));

    // Heater/cooler conflict: cooler wins; heater follows once the cooler is no longer ON.
    step("conf_rst", 1, 0, 0, 0, 400, ex(0, 0, 0, 0, 0, 0));
    step("conf_cooler", 0, 1, 1, 0, 400, ex(0, 1, 0, 150, 1, 0));
    step("conf_hold", 0, 1, 1, 0, 400, ex(0, 1, 0, 150, 1, 0));
    for (int i = 0; i < 6; i++) begin
      step($sformatf("cooler_min_on%0d", i), 0, 1, 0, 0, 400, ex(0, 1, 0, 150, 0, 0));
    end
    step("cooler_release", 0, 1, 0, 0, 400, ex(0, 0, 0, 0, 0, 0));
    step("heater_after_cooler", 0, 1, 0, 0, 400, ex(1, 0, 0, 200, 0, 0));

    // Two-cycle heater pulse: exactly MIN_ON cycles on, then lockout before re-grant.
    step("pulse_rst", 1, 0, 0, 0, 400, ex(0, 0, 0, 0, 0, 0));
    step("pulse_on0", 0, 1, 0, 0, 400, ex(1, 0, 0, 200, 0, 0));
    step("pulse_on1", 0, 1, 0, 0, 400, ex(1, 0, 0, 200, 0, 0));
    for (int i = 2; i < 8; i++) begin
      step($sformatf("pulse_on%0d", i), 0, 0, 0, 0, 400, ex(1, 0, 0, 200, 0, 0));
    end
    step("pulse_release", 0, 0, 0, 0, 400, ex(0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) begin
      step($sformatf("lockout%0d", i), 0, 1, 0, 0, 400, ex(0, 0, 0, 0, 0, 0));
    end
    step("regrant", 0, 1, 0, 0, 400, ex(1, 0, 0, 200, 0, 0));

    // Over-budget shedding: light first, then cooler.
    step("shed_rst", 1, 0, 0, 0, 400, ex(0, 0, 0, 0, 0, 0));
    step("shed_cooler_on", 0, 0, 1, 1, 400, ex(0, 1, 0, 150, 0, 0));
    step("shed_light_on", 0, 0, 1, 1, 400, ex(0, 1, 1, 190, 0, 0));
    step("shed_light", 0, 0, 1, 1, 160, ex(0, 1, 0, 150, 0, 0));
    step("shed_cooler", 0, 0, 1, 1, 100, ex(0, 0, 0, 0, 0, 0));

    // Oversized heater never granted; starve alarm sets on the 16th edge and is sticky.
    step("starve_rst", 1, 0, 0, 0, 100, ex(0, 0, 0, 0, 0, 0));
    for (int i = 1; i < 16; i++) begin
      step($sformatf("starve_edge%0d", i), 0, 1, 0, 0, 100, ex(0, 0, 0, 0, 0, 0));
    end
    step("starve_edge16", 0, 1, 0, 0, 100, ex(0, 0, 0, 0, 0, 1));
    step("starve_sticky0", 0, 0, 0, 0, 100, ex(0, 0, 0, 0, 0, 1));
    step("starve_sticky1", 0, 0, 0, 0, 100, ex(0, 0, 0, 0, 0, 1));

    // Reset mid-MIN_ON clears channels, counters and alarms; a fresh request grants at once.
    step("mid_rst", 1, 0, 0, 0, 400, ex(0, 0, 0, 0, 0, 0));
    step("mid_on0", 0, 1, 0, 0, 400, ex(1, 0, 0, 200, 0, 0));
    step("mid_on1", 0, 1, 0, 0, 400, ex(1, 0, 0, 200, 0, 0));
    step("mid_on2", 0, 1, 0, 0, 400, ex(1, 0, 0, 200, 0, 0));
    step("mid_reset", 1, 1, 1, 0, 400, ex(0, 0, 0, 0, 0, 0));
    step("post_reset_grant", 0, 1, 0, 0, 400, ex(1, 0, 0, 200, 0, 0));

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
